// File: rtl/frag_attr_sequencer.sv
// Sequences one depth job and one job per active attribute through the interpolator.
// Define FRAG_SEQ_WATCHDOG_EN to add the result timeout and the sticky err output.
module frag_attr_sequencer #(
  parameter int unsigned NUM_ATTR = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [65:0]                        in_p,
  input  logic [65:0]                        in_pa,
  input  logic [65:0]                        in_pb,
  input  logic [65:0]                        in_pc,
  input  logic [32:0]                        in_za,
  input  logic [32:0]                        in_zb,
  input  logic [32:0]                        in_zc,
  input  logic [33*NUM_ATTR-1:0]             in_fa,
  input  logic [33*NUM_ATTR-1:0]             in_fb,
  input  logic [33*NUM_ATTR-1:0]             in_fc,
  input  logic [3*NUM_ATTR-1:0]              in_aflags,
  input  logic [$clog2(NUM_ATTR+1)-1:0]      in_count,
  output logic                               ip_in_valid,
  input  logic                               ip_in_ready,
  output logic [65:0]                        ip_p,
  output logic [65:0]                        ip_pa,
  output logic [65:0]                        ip_pb,
  output logic [65:0]                        ip_pc,
  output logic [32:0]                        ip_za,
  output logic [32:0]                        ip_zb,
  output logic [32:0]                        ip_zc,
  output logic [32:0]                        ip_fa,
  output logic [32:0]                        ip_fb,
  output logic [32:0]                        ip_fc,
  output logic [3:0]                         ip_flags,
  input  logic                               ip_out_valid,
  input  logic [32:0]                        ip_f,
  input  logic [32:0]                        ip_z,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [65:0]                        out_p,
  output logic [32:0]                        out_z,
  output logic [33*NUM_ATTR-1:0]             out_attr
`ifdef FRAG_SEQ_WATCHDOG_EN
  ,
  output logic                               err
`endif
);

  localparam int unsigned CW = $clog2(NUM_ATTR + 1);
  localparam int unsigned IW = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DEPTH = 3'd1;
  localparam logic [2:0] DWAIT = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] AWAIT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          in_ready_q;
  logic [65:0]   p_q, pa_q, pb_q, pc_q;
  logic [32:0]   za_q, zb_q, zc_q;
  logic [32:0]   fa_q [NUM_ATTR];
  logic [32:0]   fb_q [NUM_ATTR];
  logic [32:0]   fc_q [NUM_ATTR];
  logic [2:0]    af_q [NUM_ATTR];
  logic [32:0]   attr_q [NUM_ATTR];
  logic [32:0]   out_z_q;
  logic [CW-1:0] count_q, count_in;
  logic [IW-1:0] idx_q;
  logic          accept, last;
  logic          res_valid;
  logic [32:0]   res_f, res_z;

  assign accept   = in_valid && in_ready_q;
  assign count_in = (in_count > CW'(NUM_ATTR)) ? CW'(NUM_ATTR) : in_count;
  assign last     = (CW'(idx_q) + CW'(1)) == count_q;

`ifdef FRAG_SEQ_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q;
  logic          err_q, waiting, expired;

  assign waiting   = (state_q == DWAIT) || (state_q == AWAIT);
  // Leaves the wait state on the TIMEOUT-th waiting cycle with a zero result.
  assign expired   = waiting && !ip_out_valid && (wd_q == WW'(TIMEOUT - 1));
  assign res_valid = ip_out_valid || expired;
  assign res_f     = ip_out_valid ? ip_f : 33'h0;
  assign res_z     = ip_out_valid ? ip_z : 33'h0;
  assign err       = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!waiting || res_valid) wd_q <= '0;
      else                       wd_q <= wd_q + WW'(1);
      if (expired) err_q <= 1'b1;
    end
  end
`else
  assign res_valid = ip_out_valid;
  assign res_f     = ip_f;
  assign res_z     = ip_z;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = DEPTH;
      DEPTH:   if (ip_in_ready) state_d = DWAIT;
      DWAIT:   if (res_valid)   state_d = (count_q == '0) ? DONE : ISSUE;
      ISSUE:   if (ip_in_ready) state_d = AWAIT;
      AWAIT:   if (res_valid)   state_d = last ? DONE : ISSUE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      p_q        <= '0;
      pa_q       <= '0;
      pb_q       <= '0;
      pc_q       <= '0;
      za_q       <= '0;
      zb_q       <= '0;
      zc_q       <= '0;
      out_z_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      for (int i = 0; i < NUM_ATTR; i++) begin
        fa_q[i]   <= '0;
        fb_q[i]   <= '0;
        fc_q[i]   <= '0;
        af_q[i]   <= '0;
        attr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        p_q     <= in_p;
        pa_q    <= in_pa;
        pb_q    <= in_pb;
        pc_q    <= in_pc;
        za_q    <= in_za;
        zb_q    <= in_zb;
        zc_q    <= in_zc;
        count_q <= count_in;
        idx_q   <= '0;
        for (int i = 0; i < NUM_ATTR; i++) begin
          fa_q[i]   <= in_fa[33*i +: 33];
          fb_q[i]   <= in_fb[33*i +: 33];
          fc_q[i]   <= in_fc[33*i +: 33];
          af_q[i]   <= in_aflags[3*i +: 3];
          attr_q[i] <= '0;
        end
      end
      if (state_q == DWAIT && res_valid) out_z_q <= res_z;
      if (state_q == AWAIT && res_valid) begin
        attr_q[idx_q] <= res_f;
        if (!last) idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign ip_in_valid = (state_q == DEPTH) || (state_q == ISSUE);
  assign out_valid   = (state_q == DONE);
  assign ip_p        = p_q;
  assign ip_pa       = pa_q;
  assign ip_pb       = pb_q;
  assign ip_pc       = pc_q;
  assign ip_za       = za_q;
  assign ip_zb       = zb_q;
  assign ip_zc       = zc_q;
  assign out_p       = p_q;
  assign out_z       = out_z_q;

  always_comb begin
    ip_fa    = '0;
    ip_fb    = '0;
    ip_fc    = '0;
    ip_flags = '0;
    if (state_q == DEPTH) begin
      ip_flags = 4'b1000;
    end else if (state_q == ISSUE) begin
      ip_fa    = fa_q[idx_q];
      ip_fb    = fb_q[idx_q];
      ip_fc    = fc_q[idx_q];
      ip_flags = {1'b0, af_q[idx_q]};
    end
  end

  always_comb begin
    out_attr = '0;
    for (int i = 0; i < NUM_ATTR; i++) out_attr[33*i +: 33] = attr_q[i];
  end

endmodule
